// File: rtl/gpr_ctx_engine.sv
// Context save/restore engine: streams GPRs out to consecutive bus words or back in.
// Save: 2 cycles/register; restore: 3 cycles/register (no wait states); holds the access until bus_rdy.
module gpr_ctx_engine #(
  parameter int REG_NUM    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int BUS_ADDR_W = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [BUS_ADDR_W-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [REG_ADDR_W-1:0] gpr_rd_addr,
  input  logic [DATA_W-1:0]     gpr_rd_data,
  output logic                  gpr_we_,
  output logic [REG_ADDR_W-1:0] gpr_wr_addr,
  output logic [DATA_W-1:0]     gpr_wr_data,
  output logic                  bus_req,
  input  logic                  bus_grnt,
  output logic                  bus_as,
  output logic                  bus_rw,
  output logic [BUS_ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0]     bus_wr_data,
  input  logic [DATA_W-1:0]     bus_rd_data,
  input  logic                  bus_rdy
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_WB, S_DONE} state_t;

  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(REG_NUM - 1);

  state_t                  state_q;
  logic                    mode_q;
  logic [BUS_ADDR_W-1:0]   base_q;
  logic [REG_ADDR_W-1:0]   idx_q;
  logic                    busy_q, done_q, bus_req_q, bus_as_q, bus_rw_q, gpr_we_q;
  logic [BUS_ADDR_W-1:0]   bus_addr_q;
  logic [DATA_W-1:0]       rd_word_q;

  logic [BUS_ADDR_W-1:0]   addr_d;
  logic [REG_ADDR_W-1:0]   idx_d;
  logic                    last_d;

  // Address wraps naturally through truncation to BUS_ADDR_W bits.
  always_comb begin
    addr_d = base_q + BUS_ADDR_W'(idx_q);
    idx_d  = idx_q + 1'b1;
    last_d = (idx_q == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      base_q     <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bus_req_q  <= 1'b0;
      bus_as_q   <= 1'b0;
      bus_rw_q   <= 1'b1;
      bus_addr_q <= '0;
      gpr_we_q   <= 1'b1;
      rd_word_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // done_q gating drops a start that coincides with the completion pulse.
          if (start && !done_q) begin
            mode_q    <= mode;
            base_q    <= base_addr;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            bus_req_q <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus_grnt) begin
            bus_as_q   <= 1'b1;
            bus_addr_q <= addr_d;
            bus_rw_q   <= mode_q;
            state_q    <= S_XFER;
          end
        end
        S_XFER: begin
          if (!bus_as_q) begin
            bus_as_q   <= 1'b1;
            bus_addr_q <= addr_d;
          end else if (bus_rdy) begin
            bus_as_q <= 1'b0;
            if (mode_q) begin
              rd_word_q <= bus_rd_data;
              gpr_we_q  <= 1'b0;
              state_q   <= S_WB;
            end else if (last_d) begin
              state_q <= S_DONE;
            end else begin
              idx_q <= idx_d;
            end
          end
        end
        S_WB: begin
          gpr_we_q <= 1'b1;
          if (last_d) begin
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_d;
            state_q <= S_XFER;
          end
        end
        S_DONE: begin
          bus_req_q <= 1'b0;
          bus_as_q  <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign bus_req     = bus_req_q;
  assign bus_as      = bus_as_q;
  assign bus_rw      = bus_rw_q;
  assign bus_addr    = bus_addr_q;
  assign gpr_rd_addr = idx_q;
  assign bus_wr_data = gpr_rd_data;
  assign gpr_we_     = gpr_we_q;
  assign gpr_wr_addr = idx_q;
  assign gpr_wr_data = rd_word_q;

endmodule

// File: tb/tb_gpr_ctx_engine.sv
// Directed bench for gpr_ctx_engine: GPR file and bus slave models with configurable grant delay and wait states.
module tb_gpr_ctx_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [29:0] base_addr = '0;
  logic        busy, done, gpr_we_, bus_req, bus_grnt, bus_as, bus_rw, bus_rdy;
  logic [4:0]  gpr_rd_addr, gpr_wr_addr;
  logic [31:0] gpr_rd_data, gpr_wr_data, bus_wr_data, bus_rd_data;
  logic [29:0] bus_addr;

  gpr_ctx_engine dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
    .busy(busy), .done(done),
    .gpr_rd_addr(gpr_rd_addr), .gpr_rd_data(gpr_rd_data),
    .gpr_we_(gpr_we_), .gpr_wr_addr(gpr_wr_addr), .gpr_wr_data(gpr_wr_data),
    .bus_req(bus_req), .bus_grnt(bus_grnt), .bus_as(bus_as), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .bus_rdy(bus_rdy)
  );

  always #5 clk = ~clk;

  // Stimulus-side knobs
  logic        clr = 1'b1;
  int          gdelay = 0;
  int          wstates = 0;
  logic [31:0] init_base = '0;

  // Model state / observation log
  int          cyc = 0;
  int          gcnt, wcnt, n_acc, we_cnt, order_err, req_ng, first_as, done_cnt, done_at;
  logic [31:0] gpr [32];
  logic [29:0] acc_addr [64];
  logic        acc_rw [64];
  logic [31:0] acc_wd [64];

  assign gpr_rd_data = gpr[gpr_rd_addr];
  assign bus_grnt    = bus_req && (gcnt >= gdelay);
  assign bus_rdy     = bus_as && (wcnt == wstates);
  assign bus_rd_data = 32'h5A5A0000 + {2'b00, bus_addr - 30'h200};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr) begin
      for (int i = 0; i < 32; i++) gpr[i] <= init_base + i;
      gcnt <= 0; wcnt <= 0; n_acc <= 0; we_cnt <= 0; order_err <= 0;
      req_ng <= 0; first_as <= -1; done_cnt <= 0; done_at <= -1;
    end else begin
      gcnt <= bus_req ? gcnt + 1 : 0;
      wcnt <= (bus_as && !bus_rdy) ? wcnt + 1 : 0;
      if (bus_req && !bus_grnt) req_ng <= req_ng + 1;
      if (bus_as && first_as < 0) first_as <= cyc;
      if (bus_as && bus_rdy) begin
        if (n_acc < 64) begin
          acc_addr[n_acc] <= bus_addr;
          acc_rw[n_acc]   <= bus_rw;
          acc_wd[n_acc]   <= bus_wr_data;
        end
        n_acc <= n_acc + 1;
      end
      if (!gpr_we_) begin
        gpr[gpr_wr_addr] <= gpr_wr_data;
        if (gpr_wr_addr != we_cnt[4:0]) order_err <= order_err + 1;
        we_cnt <= we_cnt + 1;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_at  <= cyc;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int t0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic m, input logic [29:0] b, input int gd, input int ws,
                        input logic [31:0] ib);
    @(negedge clk);
    gdelay = gd; wstates = ws; init_base = ib; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; mode = m; base_addr = b; start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0; mode = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (done_cnt == 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic check_save(input string tag, input logic [29:0] b, input int dly);
    check({tag, "_nacc"}, n_acc, 32);
    for (int i = 0; i < 32; i++) begin
      check({tag, "_addr"}, {2'b00, acc_addr[i]}, {2'b00, b + 30'(i)});
      check({tag, "_rw"}, {31'd0, acc_rw[i]}, 32'd0);
      check({tag, "_wdata"}, acc_wd[i], 32'hA5000000 + i);
    end
    check({tag, "_done_cycle"}, done_at - t0, dly);
    check({tag, "_we_pulses"}, we_cnt, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_bus_req", {31'd0, bus_req}, 0);
    check("rst_bus_as", {31'd0, bus_as}, 0);
    check("rst_bus_rw", {31'd0, bus_rw}, 1);
    check("rst_bus_addr", {2'b00, bus_addr}, 0);
    check("rst_gpr_we_", {31'd0, gpr_we_}, 1);
    check("rst_rd_addr", {27'd0, gpr_rd_addr}, 0);
    check("rst_wr_addr", {27'd0, gpr_wr_addr}, 0);
    check("rst_wr_data", gpr_wr_data, 0);
    reset = 1'b0;

    // Save, immediate grant, zero wait states
    launch(1'b0, 30'h100, 0, 0, 32'hA5000000);
    check("save_busy_c1", {31'd0, busy}, 1);
    check("save_req_c1", {31'd0, bus_req}, 1);
    check("save_as_c1", {31'd0, bus_as}, 0);
    wait_done(200);
    check("save_busy_after", {31'd0, busy}, 0);
    check("save_done_1cyc", {31'd0, done}, 0);
    check("save_req_after", {31'd0, bus_req}, 0);
    repeat (4) @(negedge clk);
    check_save("save", 30'h100, 66);
    check("save_done_cnt", done_cnt, 1);

    // Restore with 3 wait states per access
    launch(1'b1, 30'h200, 0, 3, 32'hDEAD0000);
    wait_done(400);
    repeat (4) @(negedge clk);
    check("rest_nacc", n_acc, 32);
    for (int k = 0; k < 32; k++) begin
      check("rest_gpr", gpr[k], 32'h5A5A0000 + k);
      check("rest_rw", {31'd0, acc_rw[k]}, 1);
      check("rest_addr", {2'b00, acc_addr[k]}, 32'h200 + k);
    end
    check("rest_we_pulses", we_cnt, 32);
    check("rest_we_order", order_err, 0);
    check("rest_done_cnt", done_cnt, 1);
    check("rest_done_cycle", done_at - t0, 194);

    // Grant withheld for 5 requesting cycles
    launch(1'b0, 30'h40, 5, 0, 32'hA5000000);
    wait_done(300);
    repeat (2) @(negedge clk);
    check("gnt_req_nogrant", req_ng, 5);
    check("gnt_first_as", first_as - t0, 7);
    check_save("gnt", 30'h40, 71);

    // Second start during a save must be ignored
    launch(1'b0, 30'h300, 0, 0, 32'hA5000000);
    repeat (19) @(negedge clk);
    start = 1'b1; mode = 1'b1; base_addr = 30'h999;
    @(negedge clk);
    start = 1'b0; mode = 1'b0;
    wait_done(200);
    repeat (6) @(negedge clk);
    check_save("restart", 30'h300, 66);
    check("restart_done_cnt", done_cnt, 1);

    // Reset during restore after 10 registers written
    launch(1'b1, 30'h200, 0, 0, 32'h11110000);
    for (int n = 0; n < 200 && we_cnt < 10; n++) @(negedge clk);
    check("rst10_reached", we_cnt, 10);
    reset = 1'b1;
    @(negedge clk);
    check("rst10_busy", {31'd0, busy}, 0);
    check("rst10_req", {31'd0, bus_req}, 0);
    check("rst10_we_", {31'd0, gpr_we_}, 1);
    check("rst10_as", {31'd0, bus_as}, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst10_we_cnt", we_cnt, 10);
    check("rst10_nacc", n_acc, 10);
    check("rst10_done_cnt", done_cnt, 0);
    for (int k = 0; k < 32; k++)
      check("rst10_gpr", gpr[k], (k < 10) ? 32'h5A5A0000 + k : 32'h11110000 + k);

    // Address wrap at the top of the bus space
    launch(1'b0, 30'h3FFFFFF0, 0, 0, 32'hA5000000);
    wait_done(200);
    repeat (2) @(negedge clk);
    check("wrap_nacc", n_acc, 32);
    for (int i = 0; i < 32; i++)
      check("wrap_addr", {2'b00, acc_addr[i]}, (i < 16) ? 32'h3FFFFFF0 + i : 32'(i - 16));
    check("wrap_done_cycle", done_at - t0, 66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpr_ctx_engine.md
Name: gpr_ctx_engine

Overview:
Context save/restore engine that sits on the initiator side of the general-purpose register file ports. On command it either reads all GPRs out through a register read port and writes them to consecutive bus words (save), or reads consecutive bus words and writes them into the GPRs through the register write port (restore). It is used for thread/interrupt context switching and acts as a bus master behind the existing arbiter.

Parameters:
REG_NUM, 32, number of GPRs transferred (indices 0..REG_NUM-1)
REG_ADDR_W, 5, GPR index width
DATA_W, 32, word width
BUS_ADDR_W, 30, word-address width of the bus

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
start  in  1  command strobe, sampled only in IDLE
mode  in  1  0 = save (GPR->bus), 1 = restore (bus->GPR)
base_addr  in  BUS_ADDR_W  word address of the context area, sampled with start
busy  out  1  high from the cycle after an accepted start until DONE exits
done  out  1  one-cycle completion pulse
gpr_rd_addr  out  REG_ADDR_W  GPR read-port address
gpr_rd_data  in  DATA_W  GPR read-port data (combinational from gpr_rd_addr)
gpr_we_  out  1  GPR write enable, active-low
gpr_wr_addr  out  REG_ADDR_W  GPR write address
gpr_wr_data  out  DATA_W  GPR write data
bus_req  out  1  bus request to the arbiter
bus_grnt  in  1  bus grant; the arbiter holds it while bus_req stays high
bus_as  out  1  access strobe, high while an access is outstanding
bus_rw  out  1  1 = read, 0 = write
bus_addr  out  BUS_ADDR_W  access word address
bus_wr_data  out  DATA_W  write data
bus_rd_data  in  DATA_W  read data, valid with bus_rdy
bus_rdy  in  1  one-cycle access acknowledge

Behaviour:
- All outputs and state are registered except gpr_rd_addr, bus_wr_data and gpr_wr_* (driven from registers).
- Reset: state = IDLE, idx = 0, busy = 0, done = 0, bus_req = 0, bus_as = 0, bus_rw = 1, bus_addr = 0, gpr_we_ = 1, gpr_wr_addr = 0, gpr_wr_data = 0, gpr_rd_addr = 0.
- Reset takes priority over all other inputs and aborts any transfer immediately. Registers already written remain written. No further bus or GPR activity follows the reset.
- FSM states:
  - IDLE: on start=1, latch mode and base_addr, set idx = 0 and go to REQ. Set busy = 1 and bus_req = 1 from the next cycle.
  - REQ: wait for bus_grnt=1, then go to XFER with bus_as = 1.
  - XFER:
    - bus_addr = (base + idx) mod 2^BUS_ADDR_W.
    - bus_rw = mode.
    - Save: gpr_rd_addr = idx and bus_wr_data = gpr_rd_data.
    - Hold all outputs stable until bus_rdy=1.
    - On bus_rdy in save mode: if idx = REG_NUM-1, go to DONE; otherwise increment idx and stay in XFER. There is one idle cycle with bus_as=0 between accesses, and bus_req stays high.
    - On bus_rdy in restore mode: capture bus_rd_data and go to WB.
  - WB (restore only): drive gpr_we_ = 0 for exactly one cycle, with gpr_wr_addr = idx and gpr_wr_data = the captured word. Then, if idx = REG_NUM-1, go to DONE; otherwise increment idx and go to XFER.
  - DONE: drop bus_req and bus_as, pulse done = 1 for one cycle, set busy = 0, and return to IDLE.
- start is ignored whenever state is not IDLE; a start arriving in the same cycle as the DONE pulse is ignored.
- bus_rdy is ignored unless bus_as = 1.
- Save timing with no wait states, grant in the first REQ cycle, start at cycle 0: REQ at cycle 1, first access at cycle 2, accesses every 2 cycles, done at cycle 2 + 2*REG_NUM.
- Restore with no wait states costs 3 cycles per register (access, acknowledge, WB).
- Exactly REG_NUM bus accesses occur per command. In restore mode there are exactly REG_NUM gpr_we_ pulses, with indices strictly ascending from 0.
- The address counter wraps modulo 2^BUS_ADDR_W with no error.

Test Plan:
- Save, base=0x100, GPR[i]=0xA5000000+i, grant immediate, bus_rdy same cycle as bus_as -> 32 writes to 0x100..0x11F with data 0xA5000000..0xA500001F; done pulses at cycle 66 after start; gpr_we_ stays 1 throughout.
- Restore, base=0x200, memory word k = 0x5A5A0000+k, bus_rdy delayed 3 cycles per access -> GPR[k] = 0x5A5A0000+k for k=0..31; exactly 32 gpr_we_ pulses; done pulses once.
- Grant withheld 5 cycles after start -> bus_req high and bus_as low for 5 cycles; first access only after bus_grnt=1.
- start pulsed again mid-save with mode=1 -> ignored; transfer completes as the original save; no restore occurs.
- reset asserted during restore after 10 registers -> next cycle: busy=0, bus_req=0, gpr_we_=1; GPR[0..9] hold the restored values, GPR[10..31] keep their prior contents.
- base_addr=0x3FFFFFF0, save -> addresses 0x3FFFFFF0..0x3FFFFFFF followed by 0x00000000..0x0000000F.
